start_light_sequencer: RTL and testbench

Controller for the starting-line game. It sequences NUM_LIGHTS start lights on one at a time, then arms the downstream delay block with a random hold time. When the delay block reports completion, all lights go out and the block measures the player's reaction time. It sits between the debounced push-buttons/LFSR and the delay block, LEDs and the score display.

---
 rtl/start_light_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_start_light_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/start_light_sequencer.sv
// ---------------------------------------------------------------------------
// start_light_sequencer
//
// Purpose:
//   Starting-line game controller. Turns NUM_LIGHTS start lights on one at a
//   time (each held LIGHT_PERIOD cycles), then issues a one-cycle arm pulse
//   with a random hold value to the downstream delay block. When the delay
//   block reports completion, all lights go out and the player's reaction
//   time is counted in units of REACT_TICK cycles until the player presses.
//
// Optional feature (compile-time macro):
//   START_LIGHT_SEQUENCER_FALSE_START_EN
//     Defined   : a press before the lights go out enters a FALSE state
//                 (all lights on, o_falseStart high) until the next start.
//     Undefined : early presses are ignored and o_falseStart is tied low.
//
// Ports:
//   i_clk             clock
//   i_rst             synchronous active-high reset
//   i_start           single-cycle start pulse
//   i_react           single-cycle player pulse
//   i_random          free-running random value (DELAY_W bits)
//   i_delayComplete   completion flag from the delay block
//   o_sampleAndStart  one-cycle arm pulse to the delay block
//   o_delay           hold value, valid with o_sampleAndStart (held after)
//   o_lights          start lights, bit0 lit first
//   o_reactionTime    measured reaction in REACT_TICK units (saturating)
//   o_reactionValid   o_reactionTime is a finished measurement
//   o_falseStart      false start flagged (feature builds only)
//   o_busy            high while a sequence/measurement is in progress
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module start_light_sequencer #(
  parameter int NUM_LIGHTS   = 5,
  parameter int LIGHT_PERIOD = 50000000,
  parameter int DELAY_W      = 7,
  parameter int REACT_W      = 16,
  parameter int REACT_TICK   = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_react,
  input  logic [DELAY_W-1:0]    i_random,
  input  logic                  i_delayComplete,
  output logic                  o_sampleAndStart,
  output logic [DELAY_W-1:0]    o_delay,
  output logic [NUM_LIGHTS-1:0] o_lights,
  output logic [REACT_W-1:0]    o_reactionTime,
  output logic                  o_reactionValid,
  output logic                  o_falseStart,
  output logic                  o_busy
);

  localparam int PCW = (LIGHT_PERIOD > 1) ? $clog2(LIGHT_PERIOD) : 1;
  localparam int TCW = (REACT_TICK > 1) ? $clog2(REACT_TICK) : 1;

  localparam logic [PCW-1:0]        PERIOD_LAST = PCW'(LIGHT_PERIOD - 1);
  localparam logic [PCW-1:0]        PERIOD_ONE  = PCW'(1);
  localparam logic [TCW-1:0]        TICK_LAST   = TCW'(REACT_TICK - 1);
  localparam logic [TCW-1:0]        TICK_ONE    = TCW'(1);
  localparam logic [NUM_LIGHTS-1:0] LIGHTS_ALL  = '1;
  localparam logic [NUM_LIGHTS-1:0] LIGHT_FIRST = NUM_LIGHTS'(1);
  localparam logic [REACT_W-1:0]    REACT_MAX   = '1;
  localparam logic [REACT_W-1:0]    REACT_ONE   = REACT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LIGHTS = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GO     = 3'd4,
    ST_DONE   = 3'd5
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
    ,
    ST_FALSE  = 3'd6
`endif
  } state_t;

  state_t         state;
  logic [PCW-1:0] period_cnt;
  logic [TCW-1:0] tick_cnt;
  logic           do_start;

  // A start pulse is only honoured in the resting states; everywhere else
  // a sequence is already running and the pulse is dropped.
  always_comb begin
    do_start = 1'b0;
    case (state)
      ST_IDLE,
      ST_DONE:  do_start = i_start;
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
      ST_FALSE: do_start = i_start;
`endif
      default:  do_start = 1'b0;
    endcase
  end

`ifndef START_LIGHT_SEQUENCER_FALSE_START_EN
  assign o_falseStart = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      period_cnt       <= '0;
      tick_cnt         <= '0;
      o_sampleAndStart <= 1'b0;
      o_delay          <= '0;
      o_lights         <= '0;
      o_reactionTime   <= '0;
      o_reactionValid  <= 1'b0;
      o_busy           <= 1'b0;
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
      o_falseStart     <= 1'b0;
`endif
    end else begin
      // Arm pulse is exactly one cycle wide: only the LIGHTS->ARM
      // transition below re-asserts it.
      o_sampleAndStart <= 1'b0;

      if (do_start) begin
        // New run: first light on, previous result discarded.
        state           <= ST_LIGHTS;
        period_cnt      <= '0;
        o_lights        <= LIGHT_FIRST;
        o_reactionTime  <= '0;
        o_reactionValid <= 1'b0;
        o_busy          <= 1'b1;
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
        o_falseStart    <= 1'b0;
`endif
      end else begin
        case (state)
          ST_LIGHTS: begin
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
            if (i_react) begin
              state           <= ST_FALSE;
              o_lights        <= LIGHTS_ALL;
              o_falseStart    <= 1'b1;
              o_reactionValid <= 1'b0;
              o_busy          <= 1'b0;
            end else
`endif
            if (period_cnt == PERIOD_LAST) begin
              period_cnt <= '0;
              if (o_lights == LIGHTS_ALL) begin
                // Capture the random value here so it is stable for the
                // whole ARM cycle regardless of the free-running LFSR.
                state            <= ST_ARM;
                o_sampleAndStart <= 1'b1;
                o_delay          <= i_random;
              end else begin
                o_lights <= (o_lights << 1) | LIGHT_FIRST;
              end
            end else begin
              period_cnt <= period_cnt + PERIOD_ONE;
            end
          end

          ST_ARM: begin
            // The delay block's completion flag is stale until it has seen
            // the arm pulse, so it is deliberately not looked at here.
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
            if (i_react) begin
              state           <= ST_FALSE;
              o_lights        <= LIGHTS_ALL;
              o_falseStart    <= 1'b1;
              o_reactionValid <= 1'b0;
              o_busy          <= 1'b0;
            end else
`endif
            state <= ST_WAIT;
          end

          ST_WAIT: begin
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
            if (i_react) begin
              state           <= ST_FALSE;
              o_lights        <= LIGHTS_ALL;
              o_falseStart    <= 1'b1;
              o_reactionValid <= 1'b0;
              o_busy          <= 1'b0;
            end else
`endif
            if (i_delayComplete) begin
              state          <= ST_GO;
              o_lights       <= '0;
              o_reactionTime <= '0;
              tick_cnt       <= '0;
            end
          end

          ST_GO: begin
            if (i_react) begin
              // The press freezes the current count; a tick landing in the
              // same cycle is not applied.
              state           <= ST_DONE;
              o_reactionValid <= 1'b1;
              o_busy          <= 1'b0;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (o_reactionTime != REACT_MAX) begin
                o_reactionTime <= o_reactionTime + REACT_ONE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end

          default: begin
            // IDLE, DONE and FALSE hold their outputs until a start pulse.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_start_light_sequencer.sv
// ---------------------------------------------------------------------------
// tb_start_light_sequencer
//
// Directed bench for start_light_sequencer with NUM_LIGHTS=3, LIGHT_PERIOD=4,
// REACT_TICK=2, REACT_W=4. A small delay-block model is attached: it loads
// the hold value D on the arm pulse and raises completion when its counter
// (0 in the first cycle after ARM) equals D; the counter keeps running and
// wraps, producing later stale pulses. force_dc lets the bench hold the
// completion line high independently of the model.
// Cycle numbering: cycle 0 is the cycle in which i_start is driven; cycle n
// is the interval after the n-th following rising edge.
// ---------------------------------------------------------------------------
module tb_start_light_sequencer;

  localparam int NL = 3;
  localparam int LP = 4;
  localparam int DW = 7;
  localparam int RW = 4;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          react = 1'b0;
  logic [DW-1:0] rnd = '0;
  logic          force_dc = 1'b0;
  logic          dc;
  logic          sas;
  logic [DW-1:0] dly;
  logic [NL-1:0] lights;
  logic [RW-1:0] rtime;
  logic          rvalid;
  logic          fstart;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // delay block model
  logic          running;
  logic [7:0]    mcnt;
  logic [DW-1:0] mval;

  always @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      mcnt    <= '0;
      mval    <= '0;
    end else if (sas) begin
      running <= 1'b1;
      mcnt    <= '0;
      mval    <= dly;
    end else if (running) begin
      mcnt <= mcnt + 8'd1;
    end
  end

  assign dc = (running && ({1'b0, mval} == mcnt)) || force_dc;

  always #5 clk = ~clk;

  start_light_sequencer #(
    .NUM_LIGHTS  (NL),
    .LIGHT_PERIOD(LP),
    .DELAY_W     (DW),
    .REACT_W     (RW),
    .REACT_TICK  (RT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_react         (react),
    .i_random        (rnd),
    .i_delayComplete (dc),
    .o_sampleAndStart(sas),
    .o_delay         (dly),
    .o_lights        (lights),
    .o_reactionTime  (rtime),
    .o_reactionValid (rvalid),
    .o_falseStart    (fstart),
    .o_busy          (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    rst = 1'b1;
    step();
    step();
    outs = {sas, dly, lights, rtime, rvalid, fstart, busy};
    checks++;
    if (outs !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", outs);
    end
    rst = 1'b0;
    step();
    outs = {sas, dly, lights, rtime, rvalid, fstart, busy};
    checks++;
    if (outs !== 18'd0) begin
      failures++;
      $display("FAIL idle_outputs got=%b exp=0", outs);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  // Full run: i_random=3, GO at cycle 18, press at cycle 25 -> 3 ticks.
  task automatic test_sequence();
    logic [NL-1:0] el;
    rnd = 7'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      el = (c <= 4) ? 3'b001 : (c <= 8) ? 3'b011 : 3'b111;
      checks++;
      if (lights !== el) begin
        failures++;
        $display("FAIL seq_lights cycle=%0d got=%b exp=%b", c, lights, el);
      end
      checks++;
      if (sas !== (c == 13)) begin
        failures++;
        $display("FAIL seq_arm cycle=%0d got=%b exp=%b", c, sas, (c == 13));
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL seq_busy cycle=%0d got=%b exp=1", c, busy);
      end
      if (c >= 13) begin
        checks++;
        if (dly !== 7'd3) begin
          failures++;
          $display("FAIL seq_delay cycle=%0d got=%0d exp=3", c, dly);
        end
      end
      if (c == 13) rnd = 7'd9;
      step();
    end
    for (int c = 18; c <= 24; c++) begin
      checks++;
      if (lights !== 3'b000) begin
        failures++;
        $display("FAIL go_lights cycle=%0d got=%b exp=000", c, lights);
      end
      checks++;
      if (rtime !== RW'((c - 18) / 2)) begin
        failures++;
        $display("FAIL go_count cycle=%0d got=%0d exp=%0d", c, rtime, (c - 18) / 2);
      end
      step();
    end
    react = 1'b1;
    step();
    react = 1'b0;
    checks++;
    if ({rtime, rvalid, busy} !== {4'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL done_result got=t%0d v%b b%b exp=t3 v1 b0", rtime, rvalid, busy);
    end
    react = 1'b1;
    step();
    react = 1'b0;
    step();
    step();
    checks++;
    if ({rtime, rvalid, busy, lights} !== {4'd3, 1'b1, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL done_hold got=t%0d v%b b%b l%b exp=t3 v1 b0 l000", rtime, rvalid, busy, lights);
    end
    $display("test_sequence done checks=%0d failures=%0d", checks, failures);
  endtask

  // Restart from DONE with i_random=0, completion forced high through LIGHTS
  // and ARM, and a stray start at cycle 6.
  task automatic test_zero_delay();
    logic [NL-1:0] el;
    rnd = 7'd0;
    force_dc = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({rvalid, rtime} !== 5'd0) begin
      failures++;
      $display("FAIL restart_clear got=v%b t%0d exp=v0 t0", rvalid, rtime);
    end
    for (int c = 1; c <= 14; c++) begin
      el = (c <= 4) ? 3'b001 : (c <= 8) ? 3'b011 : 3'b111;
      checks++;
      if (lights !== el) begin
        failures++;
        $display("FAIL zd_lights cycle=%0d got=%b exp=%b", c, lights, el);
      end
      checks++;
      if (sas !== (c == 13)) begin
        failures++;
        $display("FAIL zd_arm cycle=%0d got=%b exp=%b", c, sas, (c == 13));
      end
      start = (c == 6);
      if (c == 13) force_dc = 1'b0;
      step();
    end
    start = 1'b0;
    checks++;
    if ({lights, rtime, busy} !== {3'b000, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL zd_go got=l%b t%0d b%b exp=l000 t0 b1", lights, rtime, busy);
    end
    $display("test_zero_delay done checks=%0d failures=%0d", checks, failures);
  endtask

  // Continues in GO from test_zero_delay: no press for 42 cycles.
  task automatic test_saturation();
    int e;
    for (int g = 0; g <= 41; g++) begin
      e = (g / 2 > 15) ? 15 : g / 2;
      checks++;
      if (rtime !== RW'(e)) begin
        failures++;
        $display("FAIL sat_count g=%0d got=%0d exp=%0d", g, rtime, e);
      end
      step();
    end
    react = 1'b1;
    step();
    react = 1'b0;
    checks++;
    if ({rtime, rvalid, busy} !== {4'd15, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sat_done got=t%0d v%b b%b exp=t15 v1 b0", rtime, rvalid, busy);
    end
    $display("test_saturation done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    logic [17:0] outs;
    rnd = 7'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    checks++;
    if ({lights, busy} !== {3'b111, 1'b1}) begin
      failures++;
      $display("FAIL rst_wait_state got=l%b b%b exp=l111 b1", lights, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    outs = {sas, dly, lights, rtime, rvalid, fstart, busy};
    checks++;
    if (outs !== 18'd0) begin
      failures++;
      $display("FAIL rst_in_wait got=%b exp=0", outs);
    end
    rnd = 7'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    checks++;
    if ({lights, busy} !== {3'b000, 1'b1}) begin
      failures++;
      $display("FAIL rst_go_state got=l%b b%b exp=l000 b1", lights, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    outs = {sas, dly, lights, rtime, rvalid, fstart, busy};
    checks++;
    if (outs !== 18'd0) begin
      failures++;
      $display("FAIL rst_in_go got=%b exp=0", outs);
    end
    step();
    outs = {sas, dly, lights, rtime, rvalid, fstart, busy};
    checks++;
    if (outs !== 18'd0) begin
      failures++;
      $display("FAIL rst_idle_after got=%b exp=0", outs);
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  // Press at cycle 6 during LIGHTS, i_random=1.
  task automatic test_false_start();
    rnd = 7'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    react = 1'b1;
    step();
    react = 1'b0;
`ifdef START_LIGHT_SEQUENCER_FALSE_START_EN
    checks++;
    if ({fstart, lights, busy, rvalid} !== {1'b1, 3'b111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fs_enter got=f%b l%b b%b v%b exp=f1 l111 b0 v0", fstart, lights, busy, rvalid);
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({sas, fstart, lights} !== {1'b0, 1'b1, 3'b111}) begin
        failures++;
        $display("FAIL fs_hold k=%0d got=a%b f%b l%b exp=a0 f1 l111", k, sas, fstart, lights);
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({fstart, lights, busy} !== {1'b0, 3'b001, 1'b1}) begin
      failures++;
      $display("FAIL fs_restart got=f%b l%b b%b exp=f0 l001 b1", fstart, lights, busy);
    end
`else
    for (int c = 7; c <= 15; c++) begin
      checks++;
      if ({sas, fstart} !== {(c == 13), 1'b0}) begin
        failures++;
        $display("FAIL nofs_arm cycle=%0d got=a%b f%b exp=a%b f0", c, sas, fstart, (c == 13));
      end
      if (c == 7) begin
        checks++;
        if (lights !== 3'b011) begin
          failures++;
          $display("FAIL nofs_lights cycle=7 got=%b exp=011", lights);
        end
      end
      step();
    end
    checks++;
    if ({lights, busy} !== {3'b000, 1'b1}) begin
      failures++;
      $display("FAIL nofs_go got=l%b b%b exp=l000 b1", lights, busy);
    end
    react = 1'b1;
    step();
    react = 1'b0;
    checks++;
    if ({rtime, rvalid} !== {4'd0, 1'b1}) begin
      failures++;
      $display("FAIL nofs_done got=t%0d v%b exp=t0 v1", rtime, rvalid);
    end
`endif
    $display("test_false_start done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_zero_delay();
    test_saturation();
    test_reset_mid();
    test_false_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
